// File: rtl/sub_serial_8.sv
// Bit-serial subtractor: diff = a - b - b_in, one bit per clock, LSB first.
// Operands are captured on an accepted start; diff/b_out update only on completion.
module sub_serial_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    function automatic logic diff_bit(input logic ai, input logic bi, input logic bri);
        return ai ^ bi ^ bri;
    endfunction

    function automatic logic borrow_next(input logic ai, input logic bi, input logic bri);
        return (~ai & bi) | (~(ai ^ bi) & bri);
    endfunction

    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] r_nxt;

    always_comb begin
        d_bit  = diff_bit(a_sr[0], b_sr[0], br);
        br_nxt = borrow_next(a_sr[0], b_sr[0], br);
        r_nxt  = {d_bit, r_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            b_out <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // DONE behaves like IDLE so a start on the done cycle chains with no gap
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= b_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= r_nxt;
                    br   <= br_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        diff  <= r_nxt;
                        b_out <= br_nxt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial_8.sv
// Testbench for sub_serial_8: directed cases plus randomized operations checked
// against an arithmetic reference (a - b - b_in with 9-bit borrow view).
module tb_sub_serial_8;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             b_in = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;

    int n_cmp = 0;
    int n_bad = 0;

    sub_serial_8 #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .b_in (b_in),
        .busy (busy),
        .done (done),
        .diff (diff),
        .b_out(b_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a start request; called at a negedge so the next posedge accepts it.
    task automatic launch(input logic [7:0] xa, input logic [7:0] xb, input logic xbin);
        start = 1'b1;
        a     = xa;
        b     = xb;
        b_in  = xbin;
    endtask

    // Wait for the result of a launched op and compare with the arithmetic reference.
    task automatic collect(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                           input logic xbin, input bit hold, input bit check_idle);
        int       nb;
        int       cyc;
        bit       seen;
        int       ref_full;
        int       back;
        nb   = 0;
        cyc  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (busy) nb++;
            if (hold && nb < WIDTH) begin
                start = 1'b1;
                a     = 8'($urandom);
                b     = 8'($urandom);
                b_in  = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        ref_full = int'(xa) - int'(xb) - int'(xbin);
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(WIDTH + 1));
        chk({tag, "_busy_cycles"}, 32'(nb), 32'(WIDTH));
        chk({tag, "_diff"}, 32'(diff), 32'(ref_full & 8'hFF));
        chk({tag, "_b_out"}, 32'(b_out), 32'(ref_full < 0));
        back = (int'(diff) + int'(xb) + int'(xbin)) & 8'hFF;
        chk({tag, "_roundtrip"}, 32'(back), 32'(xa));
        if (check_idle) begin
            @(negedge clk);
            chk({tag, "_done_pulse"}, 32'(done), 32'd0);
            chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                          input logic xbin);
        launch(xa, xb, xbin);
        collect(tag, xa, xb, xbin, 1'b0, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_b_out", 32'(b_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        run_op("c1a", 8'h0F, 8'h01, 1'b0);
        run_op("c1b", 8'h0F, 8'h01, 1'b1);
        run_op("c2a", 8'h00, 8'h01, 1'b0);
        run_op("c2b", 8'h55, 8'h55, 1'b1);
        run_op("c3a", 8'hAA, 8'h55, 1'b0);
        run_op("c3b", 8'hF0, 8'h0F, 1'b1);
        run_op("edge_max", 8'hFF, 8'h00, 1'b0);
        run_op("edge_all", 8'h00, 8'hFF, 1'b1);

        // start held through SHIFT with changing operands, then chained on the done cycle
        launch(8'h3C, 8'h5A, 1'b1);
        collect("hold", 8'h3C, 8'h5A, 1'b1, 1'b1, 1'b0);
        launch(8'h81, 8'h7E, 1'b0);
        collect("chain", 8'h81, 8'h7E, 1'b0, 1'b0, 1'b1);

        // reset during the 4th busy cycle aborts without done
        launch(8'h12, 8'h34, 1'b0);
        begin
            int nb;
            nb = 0;
            for (int i = 0; i < 20 && nb < 4; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (busy) nb++;
            end
            chk("abort_reached", 32'(nb), 32'd4);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_b_out", 32'(b_out), 32'd0);
        repeat (WIDTH + 2) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        run_op("post_abort", 8'hC3, 8'h3D, 1'b1);

        for (int k = 0; k < 1000; k++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rbin;
            bit         rhold;
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            rbin  = 1'($urandom);
            rhold = ($urandom_range(0, 7) == 0);
            launch(ra, rb, rbin);
            collect("rand", ra, rb, rbin, rhold, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("rand_done_pulse", 32'(done), 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
